i2c_slave_responder: RTL and testbench
======================================

# i2c_slave_responder

Responder end of the on-board I2C control bus. It sits on a slave card (Mercury, Penny), fed by that card's SCL/SDA pins. It answers the 16-bit word transactions the Metis-side master issues: it returns a two-byte status/version word on reads and captures a two-byte command word on writes. All bus activity is oversampled by the card's system clock; nothing is clocked by SCL.

## Interface
- SLAVE_ADDR, 7'h10: 7-bit bus address this instance answers.
- clock  in  1  system clock; must be ≥16× SCL (12.5 MHz vs 200 kHz in use).
- reset_n  in  1  asynchronous, active-low reset.
- scl_in  in  1  SCL pin value (asynchronous).
- sda_in  in  1  SDA pin value (asynchronous).
- sda_oe  out  1  1 = pull SDA low; 0 = release. Pad is open-drain, so the block never drives high.
- rd_data  in  16  word returned on reads: [15:8] first byte, [7:0] second byte.
- wr_data  out  16  last complete write word.
- wr_strobe  out  1  one-cycle pulse when wr_data updates.
- rd_strobe  out  1  one-cycle pulse when rd_data is snapshotted for a read.
- busy  out  1  high from address match until STOP, repeated START, or reset.

## Operation
- Front end
  - scl_in and sda_in each pass through a 2-FF synchronizer, then one history flop for edge detection.
  - START: synced SDA falls while synced SCL is high.
  - STOP: synced SDA rises while synced SCL is high.
- States: IDLE, ADDR, ADDR_ACK, RD_BYTE, RD_ACK, WR_BYTE, WR_ACK, IGNORE.
- IDLE: waits for START, then goes to ADDR with a cleared bit counter.
- ADDR: shifts SDA MSB-first on each SCL rise, 8 bits. Bits [7:1] are the address; bit 0 is R/W (1 = read).
  - Match: go to ADDR_ACK.
  - Mismatch: go to IGNORE.
- ADDR_ACK:
  - On the SCL fall after bit 8, assert sda_oe, set busy, clear the byte index.
  - On a read, snapshot rd_data into the shift register and pulse rd_strobe.
  - On the next SCL fall, release (write) or present the first bit (read), then enter RD_BYTE or WR_BYTE.
- RD_BYTE:
  - sda_oe = ~shift[7]; the shift advances on each SCL fall.
  - After 8 bits, release SDA on the fall and go to RD_ACK.
- RD_ACK: samples SDA on the SCL rise.
  - ACK (0): load the next byte and return to RD_BYTE. After byte 1 the next byte is byte 0 of the same snapshot, so reads wrap.
  - NACK (1): go to IGNORE.
- WR_BYTE: shifts SDA on SCL rise, 8 bits, then enters WR_ACK.
- WR_ACK: asserts sda_oe for one SCL low phase.
  - After byte 0: hold the byte internally.
  - After byte 1: wr_data ← {byte0, byte1}, pulse wr_strobe.
  - Bytes beyond the second are NACKed (sda_oe stays 0) and discarded.
- IGNORE: keeps sda_oe = 0 until the next START or STOP.
- START in any state except IDLE (repeated START): go to ADDR, release SDA, clear busy. A partial write word is discarded.
- STOP in any state: go to IDLE, sda_oe = 0, busy = 0. A partial write word (1 byte) produces no wr_strobe.
- START/STOP detection takes priority over SCL-edge data actions in the same cycle.

## Timing
- Reset values: sda_oe 0, wr_data 16'h0000, wr_strobe 0, rd_strobe 0, busy 0, state IDLE. Reset is asynchronous at any point and releases SDA immediately.
- Edge-detect latency: a pin edge becomes visible in the system domain 3 clocks later.
- sda_oe changes on the clock after the SCL-fall detect, which keeps it well inside the SCL low phase at ≥16× oversampling.
- sda_oe never changes while synced SCL is high, except when released by STOP or reset.
- rd_strobe: pulses in the same cycle the snapshot is taken (ADDR_ACK entry on a read). rd_data changes after the snapshot do not affect the transfer.
- wr_strobe: pulses in the cycle wr_data updates, at the SCL fall that begins the second data byte's ACK.

## Test plan
- Read: SLAVE_ADDR 7'h10, rd_data 16'h01A5, master reads 0x21 with ACK, ACK, NACK, STOP → address ACK low, bytes 0x01 then 0xA5 on SDA, one rd_strobe, busy high then low after STOP.
- Write: master writes 0x20, 0x08, 0x10, STOP → three ACKs, wr_data = 16'h0810, exactly one wr_strobe, sda_oe 0 after STOP.
- Address mismatch: master reads 0x2B (addr 0x15) → sda_oe stays 0 for the whole transfer, no strobes, busy stays 0.
- Wrap and isolation: read with four ACKed bytes, rd_data changed to 16'hFFFF after the address ACK → bytes 0x01, 0xA5, 0x01, 0xA5.
- Aborts:
  - Write 0x20, 0x08, then repeated START and a read → no wr_strobe, wr_data unchanged, read proceeds normally.
  - Same write with STOP instead of repeated START → no wr_strobe.
- Reset mid-transfer: assert reset_n low during RD_BYTE while sda_oe is 1 → sda_oe 0 at once, all outputs at reset values. The next full transaction completes correctly.

Source files
------------

// File: rtl/i2c_slave_responder.sv
// I2C word responder for slave cards: oversamples SCL/SDA on the system clock,
// returns a 16-bit status word on reads and captures a 16-bit command word on writes.
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR = 7'h10
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] rd_data,
    output logic [15:0] wr_data,
    output logic        wr_strobe,
    output logic        rd_strobe,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RD_BYTE, RD_ACK, WR_BYTE, WR_ACK, IGNORE
    } state_t;

    state_t state, state_next;

    logic [2:0]  scl_pipe, sda_pipe;
    logic        scl_sync, scl_prev, sda_sync, sda_prev;
    logic        start_det, stop_det, rise_ev, fall_ev;
    logic [7:0]  shift;
    logic [15:0] rd_snap;
    logic [7:0]  byte0;
    logic [2:0]  bit_cnt;
    logic [1:0]  byte_idx;
    logic        ack_phase;
    logic        rw;
    logic        sda_oe_d, busy_d, rd_strobe_d, wr_strobe_d;

    // Pipes reset to 1 (idle bus) so reset release never looks like a START.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_pipe <= 3'b111;
            sda_pipe <= 3'b111;
        end else begin
            scl_pipe <= {scl_pipe[1:0], scl_in};
            sda_pipe <= {sda_pipe[1:0], sda_in};
        end
    end

    assign scl_sync  = scl_pipe[1];
    assign scl_prev  = scl_pipe[2];
    assign sda_sync  = sda_pipe[1];
    assign sda_prev  = sda_pipe[2];
    assign start_det = scl_sync & sda_prev & ~sda_sync;
    assign stop_det  = scl_sync & ~sda_prev & sda_sync;
    assign rise_ev   = scl_sync & ~scl_prev & ~start_det & ~stop_det;
    assign fall_ev   = ~scl_sync & scl_prev & ~start_det & ~stop_det;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (stop_det) begin
            state_next = IDLE;
        end else if (start_det) begin
            state_next = ADDR;
        end else begin
            case (state)
                ADDR:     if (rise_ev && bit_cnt == 3'd7)
                              state_next = (shift[6:0] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
                ADDR_ACK: if (fall_ev && ack_phase)
                              state_next = rw ? RD_BYTE : WR_BYTE;
                RD_BYTE:  if (fall_ev && bit_cnt == 3'd7) state_next = RD_ACK;
                RD_ACK: begin
                    if (rise_ev && sda_sync)       state_next = IGNORE;
                    else if (fall_ev && ack_phase) state_next = RD_BYTE;
                end
                WR_BYTE:  if (rise_ev && bit_cnt == 3'd7) state_next = WR_ACK;
                WR_ACK:   if (fall_ev && ack_phase) state_next = WR_BYTE;
                default:  state_next = state;
            endcase
        end
    end

    // SDA only moves on SCL-fall events, so it never changes while SCL is high.
    always_comb begin
        sda_oe_d    = sda_oe;
        busy_d      = busy;
        rd_strobe_d = 1'b0;
        wr_strobe_d = 1'b0;
        if (start_det || stop_det) begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (fall_ev) begin
            case (state)
                ADDR_ACK: begin
                    if (!ack_phase) begin
                        sda_oe_d    = 1'b1;
                        busy_d      = 1'b1;
                        rd_strobe_d = rw;
                    end else begin
                        sda_oe_d = rw ? ~shift[7] : 1'b0;
                    end
                end
                RD_BYTE:  sda_oe_d = (bit_cnt == 3'd7) ? 1'b0 : ~shift[6];
                RD_ACK:   if (ack_phase) sda_oe_d = ~shift[7];
                WR_ACK: begin
                    if (!ack_phase) begin
                        sda_oe_d    = (byte_idx != 2'd2);
                        wr_strobe_d = (byte_idx == 2'd1);
                    end else begin
                        sda_oe_d = 1'b0;
                    end
                end
                default:  sda_oe_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            rd_strobe <= 1'b0;
            wr_strobe <= 1'b0;
        end else begin
            sda_oe    <= sda_oe_d;
            busy      <= busy_d;
            rd_strobe <= rd_strobe_d;
            wr_strobe <= wr_strobe_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift     <= 8'h00;
            rd_snap   <= 16'h0000;
            byte0     <= 8'h00;
            wr_data   <= 16'h0000;
            bit_cnt   <= 3'd0;
            byte_idx  <= 2'd0;
            ack_phase <= 1'b0;
            rw        <= 1'b0;
        end else if (start_det || stop_det) begin
            bit_cnt   <= 3'd0;
            ack_phase <= 1'b0;
        end else if (rise_ev) begin
            case (state)
                ADDR: begin
                    shift   <= {shift[6:0], sda_sync};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) rw <= sda_sync;
                end
                WR_BYTE: begin
                    shift   <= {shift[6:0], sda_sync};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                RD_ACK: begin
                    // Master ACK: preload the other byte of the snapshot, wrapping after byte 1.
                    if (!sda_sync) begin
                        shift     <= byte_idx[0] ? rd_snap[15:8] : rd_snap[7:0];
                        byte_idx  <= {1'b0, ~byte_idx[0]};
                        ack_phase <= 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (fall_ev) begin
            case (state)
                ADDR_ACK: begin
                    if (!ack_phase) begin
                        ack_phase <= 1'b1;
                        byte_idx  <= 2'd0;
                        if (rw) begin
                            shift   <= rd_data[15:8];
                            rd_snap <= rd_data;
                        end
                    end else begin
                        ack_phase <= 1'b0;
                        bit_cnt   <= 3'd0;
                    end
                end
                RD_BYTE: begin
                    if (bit_cnt == 3'd7) begin
                        bit_cnt <= 3'd0;
                    end else begin
                        shift   <= {shift[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                RD_ACK: begin
                    if (ack_phase) begin
                        ack_phase <= 1'b0;
                        bit_cnt   <= 3'd0;
                    end
                end
                WR_ACK: begin
                    if (!ack_phase) begin
                        ack_phase <= 1'b1;
                        if (byte_idx == 2'd0) byte0 <= shift;
                        if (byte_idx == 2'd1) wr_data <= {byte0, shift};
                        if (byte_idx != 2'd2) byte_idx <= byte_idx + 2'd1;
                    end else begin
                        ack_phase <= 1'b0;
                        bit_cnt   <= 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Scoreboard bench for i2c_slave_responder: a bit-banged I2C master drives the pins,
// expected bytes/ACKs/write words are queued and a monitor process checks them.
`timescale 1ns/1ps
module tb_i2c_slave_responder;

    localparam time Q = 80ns;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_line;
    logic        sda_oe;
    logic [15:0] rd_data = 16'h01A5;
    logic [15:0] wr_data;
    logic        wr_strobe;
    logic        rd_strobe;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    logic oe_seen = 1'b0;
    logic busy_seen = 1'b0;

    logic [7:0]  exp_byte_q[$];
    logic [7:0]  got_byte_q[$];
    logic        exp_ack_q[$];
    logic        got_ack_q[$];
    logic [15:0] exp_wr_q[$];

    assign sda_line = sda_m & ~sda_oe;

    always #5 clock = ~clock;

    i2c_slave_responder #(.SLAVE_ADDR(7'h10)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .scl_in    (scl_m),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .rd_data   (rd_data),
        .wr_data   (wr_data),
        .wr_strobe (wr_strobe),
        .rd_strobe (rd_strobe),
        .busy      (busy)
    );

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, expv);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a byte, an ACK or a write word.
    always @(negedge clock) begin
        if (got_byte_q.size() > 0) begin
            if (exp_byte_q.size() == 0) check_output("unexpected_read_byte", {24'd0, got_byte_q.pop_front()}, 32'hDEAD);
            else check_output("read_byte", {24'd0, got_byte_q.pop_front()}, {24'd0, exp_byte_q.pop_front()});
        end
        if (got_ack_q.size() > 0) begin
            if (exp_ack_q.size() == 0) check_output("unexpected_ack", {31'd0, got_ack_q.pop_front()}, 32'hDEAD);
            else check_output("slave_ack", {31'd0, got_ack_q.pop_front()}, {31'd0, exp_ack_q.pop_front()});
        end
        if (wr_strobe) begin
            wr_cnt++;
            if (exp_wr_q.size() == 0) check_output("unexpected_wr_strobe", {16'd0, wr_data}, 32'hDEAD);
            else check_output("wr_data", {16'd0, wr_data}, {16'd0, exp_wr_q.pop_front()});
        end
        if (rd_strobe) rd_cnt++;
        if (sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    task automatic bus_start();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; #Q;
        scl_m = 1'b1; #(2*Q);
        scl_m = 1'b0; #Q;
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        b = sda_line; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] b, input logic expect_ack);
        logic a;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        exp_ack_q.push_back(expect_ack);
        read_bit(a);
        got_ack_q.push_back(a);
    endtask

    task automatic read_byte(input logic [7:0] expect_byte, input logic master_ack);
        logic [7:0] v;
        logic       b;
        exp_byte_q.push_back(expect_byte);
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
        got_byte_q.push_back(v);
        write_bit(master_ack);
    endtask

    task automatic check_drained(input string name);
        #20;
        check_output({name, "_queues_empty"},
                     exp_byte_q.size() + exp_ack_q.size() + exp_wr_q.size(), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w0, r0;
        #23;
        check_output("reset_sda_oe", {31'd0, sda_oe}, 32'd0);
        check_output("reset_wr_data", {16'd0, wr_data}, 32'd0);
        check_output("reset_wr_strobe", {31'd0, wr_strobe}, 32'd0);
        check_output("reset_rd_strobe", {31'd0, rd_strobe}, 32'd0);
        check_output("reset_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        #200;

        $display("[TB] read 0x21 -> 01 A5");
        r0 = rd_cnt;
        bus_start();
        write_byte(8'h21, 1'b0);
        check_output("read_busy_after_ack", {31'd0, busy}, 32'd1);
        read_byte(8'h01, 1'b0);
        read_byte(8'hA5, 1'b1);
        bus_stop();
        check_output("read_busy_after_stop", {31'd0, busy}, 32'd0);
        check_output("read_rd_strobes", rd_cnt - r0, 32'd1);
        check_drained("read");

        $display("[TB] write 0x20 08 10");
        w0 = wr_cnt;
        exp_wr_q.push_back(16'h0810);
        bus_start();
        write_byte(8'h20, 1'b0);
        write_byte(8'h08, 1'b0);
        write_byte(8'h10, 1'b0);
        bus_stop();
        check_output("write_sda_oe_after_stop", {31'd0, sda_oe}, 32'd0);
        check_output("write_wr_strobes", wr_cnt - w0, 32'd1);
        check_output("write_wr_data", {16'd0, wr_data}, 32'h0810);
        check_drained("write");

        $display("[TB] address mismatch 0x2B");
        r0 = rd_cnt; w0 = wr_cnt;
        oe_seen = 1'b0; busy_seen = 1'b0;
        bus_start();
        write_byte(8'h2B, 1'b1);
        bus_stop();
        check_output("mismatch_oe_seen", {31'd0, oe_seen}, 32'd0);
        check_output("mismatch_busy_seen", {31'd0, busy_seen}, 32'd0);
        check_output("mismatch_strobes", (rd_cnt - r0) + (wr_cnt - w0), 32'd0);
        check_drained("mismatch");

        $display("[TB] wrap and snapshot isolation");
        r0 = rd_cnt;
        bus_start();
        write_byte(8'h21, 1'b0);
        rd_data = 16'hFFFF;
        read_byte(8'h01, 1'b0);
        read_byte(8'hA5, 1'b0);
        read_byte(8'h01, 1'b0);
        read_byte(8'hA5, 1'b1);
        bus_stop();
        check_output("wrap_rd_strobes", rd_cnt - r0, 32'd1);
        check_drained("wrap");
        rd_data = 16'h01A5;

        $display("[TB] partial write then repeated START read");
        r0 = rd_cnt; w0 = wr_cnt;
        bus_start();
        write_byte(8'h20, 1'b0);
        write_byte(8'h08, 1'b0);
        bus_start();
        write_byte(8'h21, 1'b0);
        read_byte(8'h01, 1'b0);
        read_byte(8'hA5, 1'b1);
        bus_stop();
        check_output("rstart_wr_strobes", wr_cnt - w0, 32'd0);
        check_output("rstart_wr_data", {16'd0, wr_data}, 32'h0810);
        check_output("rstart_rd_strobes", rd_cnt - r0, 32'd1);
        check_drained("rstart");

        $display("[TB] partial write then STOP");
        w0 = wr_cnt;
        bus_start();
        write_byte(8'h20, 1'b0);
        write_byte(8'h08, 1'b0);
        bus_stop();
        check_output("stop_abort_wr_strobes", wr_cnt - w0, 32'd0);
        check_output("stop_abort_busy", {31'd0, busy}, 32'd0);
        check_drained("stop_abort");

        $display("[TB] reset during read byte");
        bus_start();
        write_byte(8'h21, 1'b0);
        check_output("pre_reset_sda_oe", {31'd0, sda_oe}, 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        check_output("mid_reset_sda_oe", {31'd0, sda_oe}, 32'd0);
        check_output("mid_reset_busy", {31'd0, busy}, 32'd0);
        check_output("mid_reset_wr_data", {16'd0, wr_data}, 32'd0);
        check_output("mid_reset_strobes", {30'd0, wr_strobe, rd_strobe}, 32'd0);
        #50;
        scl_m = 1'b1;
        sda_m = 1'b1;
        #50;
        reset_n = 1'b1;
        #200;
        check_drained("reset_ack");

        $display("[TB] write after reset 0x20 12 34");
        w0 = wr_cnt;
        exp_wr_q.push_back(16'h1234);
        bus_start();
        write_byte(8'h20, 1'b0);
        write_byte(8'h12, 1'b0);
        write_byte(8'h34, 1'b0);
        bus_stop();
        check_output("post_reset_wr_strobes", wr_cnt - w0, 32'd1);
        check_output("post_reset_wr_data", {16'd0, wr_data}, 32'h1234);
        check_drained("post_reset");

        #100;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
